// File: rtl/alu_ctrl_mul_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mul_pkg
// Shared definitions for the EX-stage ALU control / multiply block:
//   - ALU slice select codes (SEL_*)
//   - R-type funct codes (FUNCT_*)
//   - main-control alu_op encodings (ALUOP_*)
//   - multiply sequencer state enum
//   - decode helper turning alu_op/funct into slice select + b-invert
// -----------------------------------------------------------------------------
package alu_ctrl_mul_pkg;

  // ALU slice select codes
  localparam logic [2:0] SEL_ADD  = 3'b010;
  localparam logic [2:0] SEL_SUB  = 3'b110;
  localparam logic [2:0] SEL_AND  = 3'b000;
  localparam logic [2:0] SEL_OR   = 3'b001;
  localparam logic [2:0] SEL_SLT  = 3'b111;
  localparam logic [2:0] SEL_ZERO = 3'b011;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  // main-control alu_op encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // multiply sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // decoded ALU control pair
  typedef struct packed {
    logic [2:0] sel;
    logic       invert;
  } alu_ctl_t;

  // Maps alu_op/funct onto the slice select and the b-invert/carry-in line.
  // multu/mfhi/mflo and unknown functs force the ALU output to zero.
  function automatic alu_ctl_t decode_alu(input logic [1:0] op, input logic [5:0] fn);
    alu_ctl_t ctl;
    ctl.sel    = SEL_ZERO;
    ctl.invert = 1'b0;
    case (op)
      ALUOP_ADD: begin
        ctl.sel    = SEL_ADD;
        ctl.invert = 1'b0;
      end
      ALUOP_SUB: begin
        ctl.sel    = SEL_SUB;
        ctl.invert = 1'b1;
      end
      ALUOP_RTYPE: begin
        case (fn)
          FUNCT_ADD: begin
            ctl.sel    = SEL_ADD;
            ctl.invert = 1'b0;
          end
          FUNCT_SUB: begin
            ctl.sel    = SEL_SUB;
            ctl.invert = 1'b1;
          end
          FUNCT_AND: begin
            ctl.sel    = SEL_AND;
            ctl.invert = 1'b0;
          end
          FUNCT_OR: begin
            ctl.sel    = SEL_OR;
            ctl.invert = 1'b0;
          end
          FUNCT_SLT: begin
            ctl.sel    = SEL_SLT;
            ctl.invert = 1'b1;
          end
          default: begin
            ctl.sel    = SEL_ZERO;
            ctl.invert = 1'b0;
          end
        endcase
      end
      default: begin
        ctl.sel    = SEL_ZERO;
        ctl.invert = 1'b0;
      end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_ctrl_mul_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mul_if
// Bus between the EX pipeline stage and the ALU control / multiply block.
//   master (pipeline): drives i_valid, alu_op, funct, op_a, op_b;
//                      receives alu_sel, alu_invert, use_hilo, hilo_result,
//                      stall, mul_done
//   slave  (alu_ctrl_mul): the opposite directions
// -----------------------------------------------------------------------------
interface alu_ctrl_mul_if #(
  parameter int WIDTH = 32
) ();

  logic             i_valid;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       alu_sel;
  logic             alu_invert;
  logic             use_hilo;
  logic [WIDTH-1:0] hilo_result;
  logic             stall;
  logic             mul_done;

  modport master (
    output i_valid, alu_op, funct, op_a, op_b,
    input  alu_sel, alu_invert, use_hilo, hilo_result, stall, mul_done
  );

  modport slave (
    input  i_valid, alu_op, funct, op_a, op_b,
    output alu_sel, alu_invert, use_hilo, hilo_result, stall, mul_done
  );

endinterface

// File: rtl/alu_ctrl_mul_mul_shift_add.sv
// -----------------------------------------------------------------------------
// mul_shift_add
// Datapath of the iterative unsigned shift-add multiplier.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : load operands, clear product and iteration counter
//   step         : perform one shift-add iteration
//   mcand_in     : multiplicand (zero-extended internally to 2*WIDTH)
//   mplr_in      : multiplier
//   prod_next    : product value after the current iteration's add
//   last         : current iteration is the final one (cnt == MUL_CYCLES-1)
// -----------------------------------------------------------------------------
module mul_shift_add #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplr_in,
  output logic [2*WIDTH-1:0] prod_next,
  output logic               last
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplr_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] prod_next_s;

  // Conditional accumulate: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    prod_next_s = prod_r;
    if (mplr_r[0]) begin
      prod_next_s = prod_r + mcand_r;
    end else begin
      prod_next_s = prod_r;
    end
  end

  assign prod_next = prod_next_s;
  assign last      = (cnt_r == CW'(MUL_CYCLES - 1));

  // Operand/product/counter registers: load on start, shift-add on step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= {(2*WIDTH){1'b0}};
      mplr_r  <= {WIDTH{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (start) begin
      mcand_r <= {{WIDTH{1'b0}}, mcand_in};
      mplr_r  <= mplr_in;
      prod_r  <= {(2*WIDTH){1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (step) begin
      prod_r  <= prod_next_s;
      mcand_r <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplr_r  <= {1'b0, mplr_r[WIDTH-1:1]};
      cnt_r   <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/alu_ctrl_mul.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mul
// EX-stage ALU control plus multu/mfhi/mflo support.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_ctrl_mul_if slave port
//            in : i_valid, alu_op, funct, op_a (multiplicand), op_b (multiplier)
//            out: alu_sel, alu_invert, use_hilo, hilo_result, stall, mul_done
// A multu accepted in IDLE or DONE stalls the pipeline for the issue cycle plus
// MUL_CYCLES iterations; HI/LO are written on the final iteration edge, so the
// DONE cycle (mul_done high) already sees the new product.
// -----------------------------------------------------------------------------
module alu_ctrl_mul
  import alu_ctrl_mul_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_ctrl_mul_if.slave  bus
);

  alu_ctl_t           ctl_s;
  logic               is_rtype_s;
  logic               is_mul_s;
  logic               is_mfhi_s;
  logic               is_mflo_s;
  state_e             state_r;
  state_e             state_nxt_s;
  logic               stall_s;
  logic               start_s;
  logic               step_s;
  logic               hilo_we_s;
  logic               last_s;
  logic [2*WIDTH-1:0] prod_next_s;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   hilo_result_s;

  // Decode does not look at i_valid; only the mul/hilo qualifiers do.
  assign ctl_s          = decode_alu(bus.alu_op, bus.funct);
  assign bus.alu_sel    = ctl_s.sel;
  assign bus.alu_invert = ctl_s.invert;

  assign is_rtype_s = bus.i_valid && (bus.alu_op == ALUOP_RTYPE);
  assign is_mul_s   = is_rtype_s && (bus.funct == FUNCT_MULTU);
  assign is_mfhi_s  = is_rtype_s && (bus.funct == FUNCT_MFHI);
  assign is_mflo_s  = is_rtype_s && (bus.funct == FUNCT_MFLO);

  mul_shift_add #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_s),
    .step      (step_s),
    .mcand_in  (bus.op_a),
    .mplr_in   (bus.op_b),
    .prod_next (prod_next_s),
    .last      (last_s)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, stall and datapath controls. A multu seen in DONE starts a
  // fresh multiply; any instruction seen in BUSY is ignored (EX is frozen).
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    start_s     = 1'b0;
    step_s      = 1'b0;
    hilo_we_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        stall_s = is_mul_s;
        if (is_mul_s) begin
          start_s     = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        step_s  = 1'b1;
        if (last_s) begin
          hilo_we_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // HI/LO capture the final product on the last iteration edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (hilo_we_s) begin
      hi_r <= prod_next_s[2*WIDTH-1:WIDTH];
      lo_r <= prod_next_s[WIDTH-1:0];
    end
  end

  // HI/LO read mux for mfhi/mflo.
  always_comb begin
    hilo_result_s = {WIDTH{1'b0}};
    if (is_mfhi_s) begin
      hilo_result_s = hi_r;
    end else if (is_mflo_s) begin
      hilo_result_s = lo_r;
    end else begin
      hilo_result_s = {WIDTH{1'b0}};
    end
  end

  assign bus.use_hilo    = is_mfhi_s || is_mflo_s;
  assign bus.hilo_result = hilo_result_s;
  assign bus.stall       = stall_s;
  assign bus.mul_done    = (state_r == ST_DONE);

endmodule

// File: doc/alu_ctrl_mul.md
Name: alu_ctrl_mul

Overview:
EX-stage control block that sits directly upstream of the 32-bit ALU built from 1-bit slices. It decodes alu_op/funct into the slice select code and the invert/carry-in line. It also owns a 32-cycle shift-add unsigned multiplier with HI/LO registers for multu/mfhi/mflo, and stalls the pipeline while a multiply is in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH bits.
MUL_CYCLES, 32, iteration count; must equal WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
i_valid  input  1  instruction in EX is valid
alu_op  input  2  main-control ALU op: 00 add, 01 sub, 10 R-type, 11 reserved
funct  input  6  R-type function field
op_a  input  WIDTH  rs operand (multiplicand)
op_b  input  WIDTH  rt operand (multiplier)
alu_sel  output  3  slice select: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 = ALU outputs zero
alu_invert  output  1  b-invert, also the bit-0 carry-in
use_hilo  output  1  EX result mux takes hilo_result instead of the ALU sum
hilo_result  output  WIDTH  HI for mfhi, LO for mflo, 0 otherwise
stall  output  1  freeze PC/IF/ID and hold EX
mul_done  output  1  one-cycle pulse; HI/LO already hold the new product

Behaviour:
- Decode is combinational and independent of i_valid.
- alu_op 00 -> sel 010, invert 0.
- alu_op 01 -> sel 110, invert 1.
- alu_op 11 -> sel 011, invert 0.
- alu_op 10, decoded by funct:
  - 100000 -> sel 010, invert 0
  - 100010 -> sel 110, invert 1
  - 100100 -> sel 000, invert 0
  - 100101 -> sel 001, invert 0
  - 101010 -> sel 111, invert 1
  - 011001 (multu), 010000 (mfhi), 010010 (mflo) -> sel 011, invert 0
  - any other funct -> sel 011, invert 0
- is_mul = i_valid & alu_op==10 & funct==011001.
- use_hilo = i_valid & alu_op==10 & funct in {010000, 010010}.
- hilo_result = HI for mfhi, LO for mflo, otherwise 0. It is combinational from the HI/LO registers.
- FSM states: IDLE, BUSY, DONE.
- IDLE or DONE:
  - stall = is_mul.
  - On is_mul: latch mcand = zero-extended op_a (2*WIDTH bits), mplr = op_b, prod = 0, cnt = 0, then go to BUSY.
  - Otherwise go to IDLE.
- BUSY:
  - stall = 1.
  - Each cycle: if mplr[0], prod += mcand (2*WIDTH bits, no overflow possible). Then mcand <<= 1, mplr >>= 1, cnt++.
  - On the edge ending the iteration with cnt==MUL_CYCLES-1: HI <= final prod upper half, LO <= lower half, go to DONE.
  - A new multu arriving during BUSY is ignored. The pipeline is frozen, so EX holds the same instruction.
- DONE: mul_done = 1, stall = 0 for the held multu. The next edge advances the pipeline.
- Latency: multu issued in cycle t -> stall high for cycles t..t+32 (33 cycles). HI/LO are updated at the end of t+32. mul_done is high in t+33.
- mfhi/mflo in the DONE cycle or later read the new HI/LO. No forwarding is needed because HI/LO are written before DONE.
- A second multu reaching EX in a DONE cycle starts immediately. It overwrites HI/LO only at its own completion.
- Reset values (asynchronous, immediate): state IDLE, HI=LO=0, prod=mcand=mplr=0, cnt=0, mul_done=0.
  - stall then follows is_mul (IDLE).
  - Reset during BUSY aborts the multiply; HI/LO remain 0.

Decomposition:
- Shared package holds:
  - the ALU select constants (SEL_ADD, SEL_SUB, SEL_AND, SEL_OR, SEL_SLT, SEL_ZERO)
  - the funct constants (ADD, SUB, AND, OR, SLT, MULTU, MFHI, MFLO)
  - the alu_op encodings
  - the FSM state enum
- One natural sub-module: mul_shift_add. It owns mcand/mplr/prod/cnt and exposes start/last.
- The top level holds the decode, the FSM, HI/LO and the stall logic.

Test Plan:
1. alu_op=10: funct 101010 -> sel 111, invert 1; funct 100100 -> sel 000, invert 0; funct 000000 -> sel 011, stall 0.
2. multu 7 x 6, then mflo/mfhi -> stall high exactly 33 cycles, mul_done pulse in cycle 34; mflo gives 0x0000002A, mfhi gives 0x00000000.
3. multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
4. rst_n low in BUSY cycle 10 -> immediately stall 0, HI=LO=0, state IDLE; then multu 3 x 5 -> LO=15, HI=0.
5. Back-to-back multu (5 x 5, then 0x10000 x 0x10000 presented in the DONE cycle) -> second issue accepted that cycle; the first result (LO=25) is readable until the second completes; final HI=0x00000001, LO=0.
6. mflo held in EX while multu 2 x 9 is in BUSY (i_valid/funct changed mid-stall) -> no restart, stall stays high; use_hilo=1, hilo_result=0x12 once DONE.
